// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, control encodings, instruction field positions
// and the ID/EX bundle carried from decode into execute.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_JM   = 4'b1010;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1110;
  localparam logic [3:0] OP_SVPC = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NEG = 3'b010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_JMP  = 2'b01;
  localparam logic [1:0] BR_Z    = 2'b10;
  localparam logic [1:0] BR_N    = 2'b11;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS_MSB  = 21;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RT_MSB  = 15;
  localparam int unsigned RT_LSB  = 10;
  localparam int unsigned IMM_MSB = 21;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_imm;
    logic       reg_wrt;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic [1:0] branch;
    logic       svpc;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [5:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } idex_t;

  function automatic logic [31:0] sext_imm(input logic [IMM_MSB:0] v);
    return {{(31 - IMM_MSB){v[IMM_MSB]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID inputs, register-file read port and the ID/EX bundle.
interface id_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            flush;
  logic [31:0]     rf_rsout;
  logic [31:0]     rf_rtout;
  logic [5:0]      rf_rs;
  logic [5:0]      rf_rt;
  logic            stall;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [5:0]      ex_rd;
  logic [31:0]     ex_rs_data;
  logic [31:0]     ex_rt_data;
  logic [31:0]     ex_imm;
  logic [2:0]      ex_alu_op;
  logic            ex_alu_imm;
  logic            ex_reg_wrt;
  logic            ex_mem_rd;
  logic            ex_mem_wr;
  logic            ex_mem_to_reg;
  logic [1:0]      ex_branch;
  logic            ex_svpc;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, rf_rsout, rf_rtout,
    output rf_rs, rf_rt, stall, ex_valid, ex_pc, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
    output ex_alu_op, ex_alu_imm, ex_reg_wrt, ex_mem_rd, ex_mem_wr, ex_mem_to_reg,
    output ex_branch, ex_svpc
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, rf_rsout, rf_rtout,
    input  rf_rs, rf_rt, stall, ex_valid, ex_pc, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
    input  ex_alu_op, ex_alu_imm, ex_reg_wrt, ex_mem_rd, ex_mem_wr, ex_mem_to_reg,
    input  ex_branch, ex_svpc
  );
endinterface

// File: rtl/id_decoder.sv
// Purely combinational opcode-to-control mapping; unknown opcodes decode as NOP.
module id_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_SVPC: begin
        o_ctrl.reg_wrt = 1'b1;
        o_ctrl.svpc    = 1'b1;
        o_ctrl.alu_imm = 1'b1;
      end
      OP_LD: begin
        o_ctrl.reg_wrt    = 1'b1;
        o_ctrl.mem_rd     = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      OP_ST:  o_ctrl.mem_wr = 1'b1;
      OP_ADD: begin
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.reg_wrt = 1'b1;
      end
      OP_INC: begin
        o_ctrl.alu_op  = ALU_ADD;
        o_ctrl.alu_imm = 1'b1;
        o_ctrl.reg_wrt = 1'b1;
      end
      OP_NEG: begin
        o_ctrl.alu_op  = ALU_NEG;
        o_ctrl.reg_wrt = 1'b1;
      end
      OP_SUB: begin
        o_ctrl.alu_op  = ALU_SUB;
        o_ctrl.reg_wrt = 1'b1;
      end
      OP_J:   o_ctrl.branch = BR_JMP;
      OP_BRZ: o_ctrl.branch = BR_Z;
      OP_BRN: o_ctrl.branch = BR_N;
      // Memory-indirect jump reads memory but never writes a register.
      OP_JM: begin
        o_ctrl.mem_rd = 1'b1;
        o_ctrl.branch = BR_JMP;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode plus ID/EX pipeline register, with load-use stall detection
// and bubble insertion on reset, flush, stall or an empty IF/ID slot.
module id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input logic         clk,
  input logic         rst,
  id_stage_if.slave   bus
);

  ctrl_t           w_ctrl;
  idex_t           w_next;
  logic [5:0]      w_rs;
  logic [5:0]      w_rt;
  logic            w_stall;
  logic            w_bubble;
  idex_t           r_ex;
  logic [PC_W-1:0] r_pc;

  assign w_rs = bus.if_instr[RS_MSB:RS_LSB];
  assign w_rt = bus.if_instr[RT_MSB:RT_LSB];

  id_decoder u_dec (
    .i_opcode (bus.if_instr[OPC_MSB:OPC_LSB]),
    .o_ctrl   (w_ctrl)
  );

  // Only a register-writing load in EX can leave its result late for this decode.
  assign w_stall = bus.if_valid & r_ex.valid & r_ex.ctrl.mem_rd & r_ex.ctrl.reg_wrt &
                   ((r_ex.rd == w_rs) | (r_ex.rd == w_rt));

  assign w_bubble = bus.flush | w_stall | ~bus.if_valid;

  always_comb begin
    w_next         = '0;
    w_next.valid   = 1'b1;
    w_next.ctrl    = w_ctrl;
    w_next.rd      = bus.if_instr[RD_MSB:RD_LSB];
    w_next.rs_data = bus.rf_rsout;
    w_next.rt_data = bus.rf_rtout;
    w_next.imm     = sext_imm(bus.if_instr[IMM_MSB:0]);
  end

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex <= '0;
      r_pc <= '0;
    end else begin
      r_ex <= w_next;
      r_pc <= bus.if_pc;
    end
  end

  assign bus.rf_rs         = w_rs;
  assign bus.rf_rt         = w_rt;
  assign bus.stall         = w_stall;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_rd         = r_ex.rd;
  assign bus.ex_rs_data    = r_ex.rs_data;
  assign bus.ex_rt_data    = r_ex.rt_data;
  assign bus.ex_imm        = r_ex.imm;
  assign bus.ex_alu_op     = r_ex.ctrl.alu_op;
  assign bus.ex_alu_imm    = r_ex.ctrl.alu_imm;
  assign bus.ex_reg_wrt    = r_ex.ctrl.reg_wrt;
  assign bus.ex_mem_rd     = r_ex.ctrl.mem_rd;
  assign bus.ex_mem_wr     = r_ex.ctrl.mem_wr;
  assign bus.ex_mem_to_reg = r_ex.ctrl.mem_to_reg;
  assign bus.ex_branch     = r_ex.ctrl.branch;
  assign bus.ex_svpc       = r_ex.ctrl.svpc;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX bundles are queued when an
// instruction is presented and compared after the capturing edge.
module tb_id_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if #(.PC_W(32)) bus ();

  id_stage #(.PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] r_ref_op;
  ctrl_t      w_ref_ctrl;

  id_decoder u_ref (
    .i_opcode (r_ref_op),
    .o_ctrl   (w_ref_ctrl)
  );

  typedef struct packed {
    logic        valid;
    logic [10:0] ctrl;
    logic [31:0] pc;
    logic [5:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_ex;
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {alu_op[2:0], alu_imm, reg_wrt, mem_rd, mem_wr, mem_to_reg, branch[1:0], svpc}
  function automatic logic [10:0] ctrl_of(input logic [3:0] op);
    logic [2:0] alu = 3'b000;
    logic       aimm = 0, wrt = 0, mrd = 0, mwr = 0, m2r = 0, sv = 0;
    logic [1:0] br = 2'b00;
    case (op)
      4'b1111: begin wrt = 1; sv = 1; aimm = 1; end
      4'b1110: begin wrt = 1; mrd = 1; m2r = 1; end
      4'b0011: mwr = 1;
      4'b0100: wrt = 1;
      4'b0101: begin aimm = 1; wrt = 1; end
      4'b0110: begin alu = 3'b010; wrt = 1; end
      4'b0111: begin alu = 3'b001; wrt = 1; end
      4'b1000: br = 2'b01;
      4'b1001: br = 2'b10;
      4'b1011: br = 2'b11;
      4'b1010: begin mrd = 1; br = 2'b01; end
      default: ;
    endcase
    return {alu, aimm, wrt, mrd, mwr, m2r, br, sv};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [5:0] rd,
                                     input logic [5:0] rs, input logic [5:0] rt);
    return {op, rd, rs, rt, 10'h000};
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {bus.ex_alu_op, bus.ex_alu_imm, bus.ex_reg_wrt, bus.ex_mem_rd, bus.ex_mem_wr,
            bus.ex_mem_to_reg, bus.ex_branch, bus.ex_svpc};
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic fl, input logic [31:0] rsd,
                      input logic [31:0] rtd);
    exp_t e;
    logic exp_stall;
    @(negedge clk);
    rst = r; bus.if_valid = v; bus.if_instr = instr; bus.if_pc = pc;
    bus.flush = fl; bus.rf_rsout = rsd; bus.rf_rtout = rtd;
    #1;
    exp_stall = v & m_ex.valid & m_ex.ctrl[5] & m_ex.ctrl[6] &
                ((m_ex.rd == instr[21:16]) | (m_ex.rd == instr[15:10]));
    check("stall", bus.stall, exp_stall);
    check("rf_rs", bus.rf_rs, instr[21:16]);
    check("rf_rt", bus.rf_rt, instr[15:10]);
    e = '0;
    if (!(r | fl | exp_stall | ~v)) begin
      e.valid = 1'b1; e.ctrl = ctrl_of(instr[31:28]); e.pc = pc; e.rd = instr[27:22];
      e.rs_data = rsd; e.rt_data = rtd; e.imm = {{10{instr[21]}}, instr[21:0]};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("ex_valid", bus.ex_valid, e.valid);
      check("ex_ctrl", dut_ctrl(), e.ctrl);
      check("ex_pc", bus.ex_pc, e.pc);
      check("ex_rd", bus.ex_rd, e.rd);
      check("ex_rs_data", bus.ex_rs_data, e.rs_data);
      check("ex_rt_data", bus.ex_rt_data, e.rt_data);
      check("ex_imm", bus.ex_imm, e.imm);
      m_ex = e;
    end
  endtask

  initial begin
    m_ex = '0;
    r_ref_op = 4'h0;
    rst = 1'b1; bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
    bus.flush = 1'b0; bus.rf_rsout = '0; bus.rf_rtout = '0;
    repeat (2) @(posedge clk);

    // Reset held with a valid ADD presented
    step(1, 1, mk(4'b0100, 6'd5, 6'd1, 6'd2), 32'h100, 0, 32'h10, 32'h20);
    step(1, 1, mk(4'b0100, 6'd5, 6'd1, 6'd2), 32'h100, 0, 32'h10, 32'h20);

    step(0, 1, mk(4'b0100, 6'd5, 6'd1, 6'd2), 32'h100, 0, 32'h10, 32'h20);
    step(0, 1, {4'b0101, 6'd6, 22'h3FFFFF}, 32'h104, 0, 32'h1, 32'h2);
    step(0, 1, {4'b0101, 6'd6, 22'h1FFFFF}, 32'h108, 0, 32'h3, 32'h4);

    // Load-use: one stall cycle, then SUB enters
    step(0, 1, mk(4'b1110, 6'd7, 6'd0, 6'd0), 32'h10C, 0, 32'hA, 32'hB);
    step(0, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h110, 0, 32'h77, 32'h0);
    step(0, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h110, 0, 32'h78, 32'h1);

    // Load then unrelated SUB: no stall
    step(0, 1, mk(4'b1110, 6'd7, 6'd0, 6'd0), 32'h114, 0, 32'hA, 32'hB);
    step(0, 1, mk(4'b0111, 6'd3, 6'd8, 6'd9), 32'h118, 0, 32'h88, 32'h99);

    // Load through rt also stalls
    step(0, 1, mk(4'b1110, 6'd7, 6'd0, 6'd0), 32'h11C, 0, 32'hA, 32'hB);
    step(0, 1, mk(4'b0100, 6'd3, 6'd8, 6'd7), 32'h120, 0, 32'h1, 32'h2);
    step(0, 1, mk(4'b0100, 6'd3, 6'd8, 6'd7), 32'h120, 0, 32'h1, 32'h2);

    // JM writes no register, so no hazard
    step(0, 1, mk(4'b1010, 6'd7, 6'd0, 6'd0), 32'h124, 0, 32'hC, 32'hD);
    step(0, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h128, 0, 32'h5, 32'h6);

    // Flush while a stall condition holds
    step(0, 1, mk(4'b1110, 6'd7, 6'd0, 6'd0), 32'h12C, 0, 32'hA, 32'hB);
    step(0, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h130, 1, 32'h5, 32'h6);
    step(0, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h130, 0, 32'h5, 32'h6);

    // Plain flush and empty slot
    step(0, 1, mk(4'b0100, 6'd1, 6'd2, 6'd3), 32'h134, 1, 32'h5, 32'h6);
    step(0, 0, mk(4'b0100, 6'd1, 6'd2, 6'd3), 32'h138, 0, 32'h5, 32'h6);

    // Every opcode through the pipe, including undefined ones
    for (int op = 0; op < 16; op++) begin
      step(0, 1, {op[3:0], 6'd10, 6'd20, 6'd21, 10'h155}, 32'h200 + op * 4, 0,
           32'h1000 + op, 32'h2000 + op);
    end

    // Reset mid-stream beats flush and stall
    step(0, 1, mk(4'b1110, 6'd7, 6'd0, 6'd0), 32'h300, 0, 32'hA, 32'hB);
    step(1, 1, mk(4'b0111, 6'd3, 6'd7, 6'd0), 32'h304, 1, 32'h5, 32'h6);
    step(0, 1, mk(4'b0100, 6'd4, 6'd1, 6'd2), 32'h308, 0, 32'h5, 32'h6);

    // Stand-alone decoder against the bench table
    for (int op = 0; op < 16; op++) begin
      r_ref_op = op[3:0];
      #1;
      check("decoder", w_ref_ctrl, ctrl_of(op[3:0]));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage and ID/EX pipeline register. It sits directly upstream of `registerfile`. It drives the `rs`/`rt` read addresses from the IF/ID instruction and decodes the opcode into control signals. It captures `rsout`/`rtout` plus controls into the ID/EX bundle consumed by execute. It also detects load-use hazards and handles branch flushes by inserting bubbles.

## Interface
- `PC_W`, 32: program-counter width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_valid` in 1: IF/ID holds a real instruction.
- `if_instr` in 32: IF/ID instruction.
- `if_pc` in PC_W: PC of `if_instr`.
- `flush` in 1: branch taken in EX; kill the instruction being decoded.
- `rf_rsout`, `rf_rtout` in 32: register-file read data.
- `rf_rs`, `rf_rt` out 6: combinational `if_instr[21:16]`, `if_instr[15:10]`.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `ex_valid` out 1: ID/EX holds a real instruction.
- `ex_pc` out PC_W, `ex_rd` out 6, `ex_rs_data`/`ex_rt_data` out 32, `ex_imm` out 32.
- `ex_alu_op` out 3, `ex_alu_imm` out 1, `ex_reg_wrt` out 1, `ex_mem_rd` out 1, `ex_mem_wr` out 1, `ex_mem_to_reg` out 1, `ex_branch` out 2, `ex_svpc` out 1.

## Operation
- Fields: opcode `[31:28]`, rd `[27:22]`, rs `[21:16]`, rt `[15:10]`, imm = sign-extended `[21:0]`.
- Opcodes and their effects:
  - NOP 0000: no effects.
  - SVPC 1111: reg_wrt, svpc, alu_imm.
  - LD 1110: reg_wrt, mem_rd, mem_to_reg.
  - ST 0011: mem_wr.
  - ADD 0100: alu_op=000, reg_wrt.
  - INC 0101: alu_op=000, alu_imm, reg_wrt.
  - NEG 0110: alu_op=010, reg_wrt.
  - SUB 0111: alu_op=001, reg_wrt.
  - J 1000: branch=01.
  - BRZ 1001: branch=10.
  - BRN 1011: branch=11.
  - JM 1010: mem_rd, branch=01.
- Undefined opcodes decode as NOP; `ex_valid` is still set.
- Load-use hazard: `stall` = `if_valid & ex_valid & ex_mem_rd & ex_reg_wrt & (ex_rd==rf_rs | ex_rd==rf_rt)`.
  - JM does not trigger the hazard, because its reg_wrt is 0.
- Register update each cycle, in priority order:
  - `rst`: bubble.
  - `flush`: bubble.
  - `stall`: bubble.
  - `if_valid=0`: bubble.
  - Otherwise: load decoded bundle and `ex_valid`=1.
- A bubble forces `ex_valid`=0 and all control bits to 0. Data fields are don't-care but are held at 0.
- `flush` and `stall` asserted together: flush wins. `stall` remains asserted combinationally; upstream ignores it when flushing.
- The block performs no arithmetic. The imm sign-extension is the only width rule: bit 21 replicates into `[31:22]`.

## Timing
- Reset: every output register is 0. `stall` is 0 because `ex_valid`=0.
- Register-file read path:
  - `rf_rs`/`rf_rt` change after posedge.
  - `registerfile` samples on negedge.
  - `rf_rsout`/`rf_rtout` are stable before the next posedge and are captured there.
- Decode-to-EX latency is 1 cycle.
- A write-back on the same negedge as a read is visible in the captured data, so WB-to-ID needs no forwarding.
- A stall lasts exactly one cycle per load-use pair. The next cycle carries the bubble, so `ex_mem_rd`=0 and the hazard clears.
- `rst` mid-stream: the next edge yields a bubble regardless of `flush`/`stall`.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants
  - alu_op encodings
  - branch encodings
  - field bit positions
  - an `idex_t` struct for the bundle
- One natural sub-module, `id_decoder`: purely combinational opcode-to-control mapping, reused by the bench as a reference model.
- Hazard logic and the pipeline register stay in `id_stage`.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with valid ADD presented -> `ex_valid`=0, all controls 0, `stall`=0.
- **ADD decode:** ADD rd=5 rs=1 rt=2, rf_rsout=0x10, rf_rtout=0x20 -> next cycle `ex_valid`=1, alu_op=000, reg_wrt=1, ex_rd=5, data 0x10/0x20, rf_rs=1, rf_rt=2 combinationally.
- **INC immediate:** INC with `[21:0]`=0x3FFFFF -> `ex_imm`=0xFFFFFFFF, alu_imm=1.
- **Load-use stall:** LD rd=7, then SUB rs=7 -> `stall`=1 for exactly one cycle and a bubble enters EX. SUB enters on the following cycle.
- **No false stall:** LD rd=7, then SUB rs=8 rt=9 -> `stall` stays 0.
- **Flush priority:** `flush`=1 while a stall condition holds -> bubble; `ex_valid`=0 next cycle. All 16 opcodes are checked against `id_decoder`; undefined opcodes yield zero controls with `ex_valid`=1.
